video_timing_pattern_gen: RTL and testbench
===========================================

Name: video_timing_pattern_gen

Overview:
- Generates raster timing and a selectable test pattern for the board's video DAC pins (vo_hsync, vo_vsync, vo_blank_, vo_r/g/b).
- Sits directly upstream of the top-level video output pins, in the pixel-clock domain that also drives vo_clk.
- Default timing is 640x480@60 (25.175 MHz nominal pixel clock).
- Timing is fully parameterised so the same block serves other modes.

Parameters:
- H_ACTIVE, 640, visible pixels per line; must be a multiple of 8.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- HS_POL, 0, asserted level of vo_hsync (0 = active-low).
- VS_POL, 0, asserted level of vo_vsync (0 = active-low).

Ports:
- clk  input  1  pixel clock
- reset  input  1  synchronous, active-high reset
- pattern_sel  input  2  pattern select: 0 = colour bars, 1 = grid, 2 = gradient, 3 = solid colour
- solid_rgb  input  24  colour for pattern 3, packed {r,g,b}
- vo_hsync  output  1  horizontal sync, level set by HS_POL
- vo_vsync  output  1  vertical sync, level set by VS_POL
- vo_blank_  output  1  active-low blank; 1 = visible pixel
- vo_r  output  8  red
- vo_g  output  8  green
- vo_b  output  8  blue
- pix_x  output  12  column of the pixel currently on the pins
- pix_y  output  12  row of the pixel currently on the pins
- frame_start  output  1  one-cycle pulse, coincident with pixel (0,0) on the pins

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Counters:
  - hcnt counts 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments only on the cycle hcnt wraps, and wraps to 0 after V_TOTAL-1.
  - Both counters are 12 bits wide.
- Active region: hcnt < H_ACTIVE && vcnt < V_ACTIVE.
- hsync asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (default 656..751).
- vsync asserted for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (default 490..491). vsync is asserted for whole lines, aligned to hcnt = 0.
- Pipeline:
  - Every output is registered, with 1 cycle latency from the counters.
  - Sync, blank, pix_x/pix_y, RGB and frame_start are mutually aligned.
  - pix_x/pix_y carry the registered hcnt/vcnt, including during blanking.
- Blanking: when not in the active region, vo_r/vo_g/vo_b = 0 and vo_blank_ = 0.
- Pattern 0, colour bars:
  - 8 bars, each H_ACTIVE/8 wide (80 px by default).
  - Order from left: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Bar index comes from a sub-counter plus a 3-bit index, both reset at hcnt = 0. No divider.
- Pattern 1, grid: FFFFFF where x[4:0] == 0 or y[4:0] == 0, otherwise 000000.
- Pattern 2, gradient: r = x[7:0], g = y[7:0], b = frame_cnt[7:0].
  - frame_cnt is an 8-bit counter that increments at each frame wrap and wraps 255 -> 0.
- Pattern 3, solid: RGB = solid_rgb.
- pattern_sel latching:
  - pattern_sel is latched only when hcnt == 0 && vcnt == 0, and the new pattern applies from that pixel on.
  - Changes mid-frame never tear the image.
  - solid_rgb is sampled live.
- frame_start: asserted on the output cycle whose pix_x = 0 and pix_y = 0.
- Reset values:
  - hcnt, vcnt, frame_cnt, bar counters = 0; latched pattern = 0.
  - vo_hsync = ~HS_POL, vo_vsync = ~VS_POL (deasserted).
  - vo_blank_ = 0; vo_r/g/b = 0; pix_x/pix_y = 0; frame_start = 0.
- After reset release:
  - Counters sit at (0,0) on the first post-reset cycle.
  - The outputs present pixel (0,0) with frame_start = 1 one cycle later.
- Reset mid-frame: takes effect on the next clk edge with the same result as reset from power-up. No partial line is completed.

Test Plan:
- Reset, then release with pattern_sel = 0 → exactly 1 cycle after release: frame_start = 1, pix = (0,0), vo_blank_ = 1, RGB = FFFFFF. Next frame_start comes 420000 cycles later (800 x 525).
- One line, default timing → vo_blank_ = 1 for 640 cycles; vo_hsync low for exactly 96 cycles, starting 656 cycles after line start; RGB = 0 throughout cycles 640..799.
- One frame → vo_vsync low for exactly 2 x 800 = 1600 cycles, starting at line 490 with hcnt = 0; vo_blank_ = 0 for all of lines 480..524.
- pattern_sel = 0 → pix_x = 79 gives FFFFFF, pix_x = 80 gives FFFF00, pix_x = 560 gives 000000. pattern_sel = 1 at (32,5) → FFFFFF; at (33,5) → 000000.
- Switch pattern_sel 0 → 3 at mid-frame line 200, with solid_rgb = 123456 → remainder of the frame is still bars; the next frame is all 123456.
- pattern_sel = 2 over 3 frames → at (10,20) RGB = 0A1400, then 0A1401, then 0A1402. Assert reset at line 300 → all outputs at reset values on the next cycle, and frame_cnt = 0.

Source files
------------

// File: rtl/video_timing_pattern_gen.sv
// Raster timing generator with a selectable test pattern for the video DAC pins.
// All outputs are registered one cycle behind the hcnt/vcnt counters.
module video_timing_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        vo_hsync,
  output logic        vo_vsync,
  output logic        vo_blank_,
  output logic [7:0]  vo_r,
  output logic [7:0]  vo_g,
  output logic [7:0]  vo_b,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start
);

  localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS     = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_VIS    = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS     = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE     = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
  localparam logic        HS_ON    = 1'(HS_POL);
  localparam logic        VS_ON    = 1'(VS_POL);

  logic [11:0] hcnt, vcnt, bar_sub;
  logic [2:0]  bar_idx;
  logic [7:0]  frame_cnt;
  logic [1:0]  pat_q;

  logic        h_wrap, v_wrap, at_origin, active, in_hs, in_vs;
  logic [1:0]  pat_cur;
  logic [23:0] bar_rgb, pix_rgb;

  assign h_wrap    = (hcnt == H_LAST);
  assign v_wrap    = (vcnt == V_LAST);
  assign at_origin = (hcnt == 12'd0) && (vcnt == 12'd0);
  assign active    = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign in_hs     = (hcnt >= H_SS) && (hcnt < H_SE);
  assign in_vs     = (vcnt >= V_SS) && (vcnt < V_SE);
  // The pattern captured at the frame origin applies to that very pixel.
  assign pat_cur   = at_origin ? pattern_sel : pat_q;

  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    pix_rgb = 24'h000000;
    case (pat_cur)
      2'd0: pix_rgb = bar_rgb;
      2'd1: pix_rgb = ((hcnt[4:0] == 5'd0) || (vcnt[4:0] == 5'd0)) ? 24'hFFFFFF : 24'h000000;
      2'd2: pix_rgb = {hcnt[7:0], vcnt[7:0], frame_cnt};
      default: pix_rgb = solid_rgb;
    endcase
  end

  // Bar sub-counter tracks hcnt so bar boundaries need no divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt      <= 12'd0;
      vcnt      <= 12'd0;
      bar_sub   <= 12'd0;
      bar_idx   <= 3'd0;
      frame_cnt <= 8'd0;
      pat_q     <= 2'd0;
    end else begin
      if (h_wrap) begin
        hcnt    <= 12'd0;
        bar_sub <= 12'd0;
        bar_idx <= 3'd0;
        if (v_wrap) begin
          vcnt      <= 12'd0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          vcnt <= vcnt + 12'd1;
        end
      end else begin
        hcnt <= hcnt + 12'd1;
        if (bar_sub == BAR_LAST) begin
          bar_sub <= 12'd0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_sub <= bar_sub + 12'd1;
        end
      end
      if (at_origin)
        pat_q <= pattern_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vo_hsync    <= ~HS_ON;
      vo_vsync    <= ~VS_ON;
      vo_blank_   <= 1'b0;
      vo_r        <= 8'd0;
      vo_g        <= 8'd0;
      vo_b        <= 8'd0;
      pix_x       <= 12'd0;
      pix_y       <= 12'd0;
      frame_start <= 1'b0;
    end else begin
      vo_hsync           <= in_hs ? HS_ON : ~HS_ON;
      vo_vsync           <= in_vs ? VS_ON : ~VS_ON;
      vo_blank_          <= active;
      {vo_r, vo_g, vo_b} <= active ? pix_rgb : 24'h000000;
      pix_x              <= hcnt;
      pix_y              <= vcnt;
      frame_start        <= at_origin;
    end
  end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Self-checking bench for video_timing_pattern_gen on a reduced 160x30 raster
// with a reference model feeding an expected-output scoreboard.
module tb_video_timing_pattern_gen;

  localparam int HA = 128, HF = 8, HSW = 16, HB = 8;
  localparam int VA = 24, VF = 2, VSW = 2, VB = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int BW = HA / 8;
  localparam logic HS_ON = 1'b0;
  localparam logic VS_ON = 1'b0;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic [23:0] rgb;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = 24'h000000;
  logic        vo_hsync, vo_vsync, vo_blank_, frame_start;
  logic [7:0]  vo_r, vo_g, vo_b;
  logic [11:0] pix_x, pix_y;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fs_cyc = 0;
  int mh = 0, mv = 0, mfc = 0;
  logic [1:0] mpat = 2'd0;
  exp_t sb[$];
  exp_t e, o;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(0), .VS_POL(0)
  ) dut (
    .clk(clk), .reset(reset), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .vo_hsync(vo_hsync), .vo_vsync(vo_vsync), .vo_blank_(vo_blank_),
    .vo_r(vo_r), .vo_g(vo_g), .vo_b(vo_b),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout cyc=%0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  function automatic exp_t obs();
    obs = {vo_hsync, vo_vsync, vo_blank_, vo_r, vo_g, vo_b, pix_x, pix_y, frame_start};
  endfunction

  // Push the expected output for the model's current pixel, then clock once.
  task automatic tick();
    exp_t x;
    logic [1:0] pat;
    logic vis;
    x = '0;
    if (reset) begin
      x.hs = ~HS_ON;
      x.vs = ~VS_ON;
      mh = 0; mv = 0; mfc = 0; mpat = 2'd0;
    end else begin
      pat = (mh == 0 && mv == 0) ? pattern_sel : mpat;
      if (mh == 0 && mv == 0) mpat = pattern_sel;
      vis = (mh < HA) && (mv < VA);
      x.hs = (mh >= HA + HF && mh < HA + HF + HSW) ? HS_ON : ~HS_ON;
      x.vs = (mv >= VA + VF && mv < VA + VF + VSW) ? VS_ON : ~VS_ON;
      x.blank = vis;
      x.x = 12'(mh);
      x.y = 12'(mv);
      x.fs = (mh == 0 && mv == 0);
      if (vis) begin
        case (pat)
          2'd0: x.rgb = bars[mh / BW];
          2'd1: x.rgb = (mh % 32 == 0 || mv % 32 == 0) ? 24'hFFFFFF : 24'h000000;
          2'd2: x.rgb = {8'(mh), 8'(mv), 8'(mfc)};
          default: x.rgb = solid_rgb;
        endcase
      end
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin
          mv = 0;
          mfc = (mfc + 1) % 256;
        end else mv++;
      end else mh++;
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL reset_state got=%h exp=%h", o, e); end
    end
    reset = 1'b0;
  endtask

  task automatic test_first_line();
    int blank_cnt, hs_cnt, hs_first, rgb_bad;
    blank_cnt = 0; hs_cnt = 0; hs_first = -1; rgb_bad = 0;
    pattern_sel = 2'd0;
    for (int i = 0; i < HT; i++) begin
      tick();
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL line0 cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (i == 0) begin
        fs_cyc = cyc;
        checks++;
        if ({frame_start, vo_blank_, pix_x, pix_y, vo_r, vo_g, vo_b} !== {2'b11, 24'd0, 24'hFFFFFF}) begin
          errors++;
          $display("[TB] FAIL first_pixel fs=%b blank=%b x=%0d y=%0d rgb=%h exp fs=1 blank=1 (0,0) FFFFFF",
                   frame_start, vo_blank_, pix_x, pix_y, {vo_r, vo_g, vo_b});
        end
      end
      if (vo_blank_ === 1'b1) blank_cnt++;
      if (vo_hsync === HS_ON) begin
        if (hs_first < 0) hs_first = i;
        hs_cnt++;
      end
      if (i >= HA && {vo_r, vo_g, vo_b} !== 24'd0) rgb_bad++;
    end
    checks++;
    if (blank_cnt !== HA) begin errors++; $display("[TB] FAIL blank_width got=%0d exp=%0d", blank_cnt, HA); end
    checks++;
    if (hs_cnt !== HSW) begin errors++; $display("[TB] FAIL hsync_width got=%0d exp=%0d", hs_cnt, HSW); end
    checks++;
    if (hs_first !== HA + HF) begin errors++; $display("[TB] FAIL hsync_start got=%0d exp=%0d", hs_first, HA + HF); end
    checks++;
    if (rgb_bad !== 0) begin errors++; $display("[TB] FAIL hblank_rgb got=%0d nonzero exp=0", rgb_bad); end
  endtask

  task automatic test_bars();
    for (int i = 0; i < HT; i++) begin
      tick();
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL bars_line cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (i == BW - 1) begin
        checks++;
        if ({vo_r, vo_g, vo_b} !== 24'hFFFFFF) begin errors++; $display("[TB] FAIL bar0_edge got=%h exp=FFFFFF", {vo_r, vo_g, vo_b}); end
      end
      if (i == BW) begin
        checks++;
        if ({vo_r, vo_g, vo_b} !== 24'hFFFF00) begin errors++; $display("[TB] FAIL bar1_start got=%h exp=FFFF00", {vo_r, vo_g, vo_b}); end
      end
      if (i == 7 * BW) begin
        checks++;
        if ({vo_r, vo_g, vo_b} !== 24'h000000) begin errors++; $display("[TB] FAIL bar7_start got=%h exp=000000", {vo_r, vo_g, vo_b}); end
      end
    end
  endtask

  task automatic test_frame();
    int vs_cnt, vs_line, vs_col, vblank_bad;
    vs_cnt = 0; vs_line = -1; vs_col = -1; vblank_bad = 0;
    for (int v = 2; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        if (v == 12 && h == 0) begin
          pattern_sel = 2'd3;
          solid_rgb = 24'h123456;
        end
        tick();
        o = obs(); e = sb.pop_front(); checks++;
        if (o !== e) begin errors++; $display("[TB] FAIL frame0 cyc=%0d got=%h exp=%h", cyc, o, e); end
        if (vo_vsync === VS_ON) begin
          if (vs_line < 0) begin vs_line = v; vs_col = h; end
          vs_cnt++;
        end
        if (v >= VA && vo_blank_ !== 1'b0) vblank_bad++;
        if (v == 20 && h == BW) begin
          checks++;
          if ({vo_r, vo_g, vo_b} !== 24'hFFFF00) begin errors++; $display("[TB] FAIL no_tear got=%h exp=FFFF00", {vo_r, vo_g, vo_b}); end
        end
      end
    end
    checks++;
    if (vs_cnt !== VSW * HT) begin errors++; $display("[TB] FAIL vsync_width got=%0d exp=%0d", vs_cnt, VSW * HT); end
    checks++;
    if (vs_line !== VA + VF || vs_col !== 0) begin
      errors++; $display("[TB] FAIL vsync_start got=(%0d,%0d) exp=(0,%0d)", vs_col, vs_line, VA + VF);
    end
    checks++;
    if (vblank_bad !== 0) begin errors++; $display("[TB] FAIL vblank got=%0d visible exp=0", vblank_bad); end
    tick();
    o = obs(); e = sb.pop_front(); checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL frame1_origin got=%h exp=%h", o, e); end
    checks++;
    if (frame_start !== 1'b1 || cyc - fs_cyc !== HT * VT) begin
      errors++; $display("[TB] FAIL frame_period fs=%b got=%0d exp=%0d", frame_start, cyc - fs_cyc, HT * VT);
    end
    checks++;
    if ({vo_r, vo_g, vo_b} !== 24'h123456) begin errors++; $display("[TB] FAIL solid_origin got=%h exp=123456", {vo_r, vo_g, vo_b}); end
  endtask

  task automatic test_solid();
    int bad;
    bad = 0;
    pattern_sel = 2'd1;
    for (int i = 1; i < HT * VT; i++) begin
      tick();
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL solid_frame cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (vo_blank_ === 1'b1 && {vo_r, vo_g, vo_b} !== 24'h123456) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL solid_pixels got=%0d wrong exp=0", bad); end
  endtask

  task automatic test_grid();
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        tick();
        o = obs(); e = sb.pop_front(); checks++;
        if (o !== e) begin errors++; $display("[TB] FAIL grid_frame cyc=%0d got=%h exp=%h", cyc, o, e); end
        if (v == 5 && h == 32) begin
          checks++;
          if ({vo_r, vo_g, vo_b} !== 24'hFFFFFF) begin errors++; $display("[TB] FAIL grid_on got=%h exp=FFFFFF", {vo_r, vo_g, vo_b}); end
        end
        if (v == 5 && h == 33) begin
          checks++;
          if ({vo_r, vo_g, vo_b} !== 24'h000000) begin errors++; $display("[TB] FAIL grid_off got=%h exp=000000", {vo_r, vo_g, vo_b}); end
        end
      end
    end
  endtask

  task automatic test_gradient();
    pattern_sel = 2'd2;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL grad_reset got=%h exp=%h", o, e); end
    end
    reset = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int v = 0; v < VT; v++) begin
        for (int h = 0; h < HT; h++) begin
          tick();
          o = obs(); e = sb.pop_front(); checks++;
          if (o !== e) begin errors++; $display("[TB] FAIL grad_frame cyc=%0d got=%h exp=%h", cyc, o, e); end
          if (v == 20 && h == 10) begin
            checks++;
            if ({vo_r, vo_g, vo_b} !== {16'h0A14, 8'(f)}) begin
              errors++; $display("[TB] FAIL gradient f=%0d got=%h exp=%h", f, {vo_r, vo_g, vo_b}, {16'h0A14, 8'(f)});
            end
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 15 * HT + 40; i++) begin
      tick();
      o = obs(); e = sb.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, o, e); end
    end
    reset = 1'b1;
    tick();
    o = obs(); e = sb.pop_front(); checks++;
    if (o !== e) begin errors++; $display("[TB] FAIL mid_reset got=%h exp=%h", o, e); end
    checks++;
    if ({vo_hsync, vo_vsync, vo_blank_, vo_r, vo_g, vo_b, pix_x, pix_y, frame_start} !== {~HS_ON, ~VS_ON, 50'd0}) begin
      errors++; $display("[TB] FAIL mid_reset_values got=%h", obs());
    end
    reset = 1'b0;
    for (int v = 0; v <= 20; v++) begin
      for (int h = 0; h < HT; h++) begin
        tick();
        o = obs(); e = sb.pop_front(); checks++;
        if (o !== e) begin errors++; $display("[TB] FAIL post_reset cyc=%0d got=%h exp=%h", cyc, o, e); end
        if (v == 0 && h == 0) begin
          checks++;
          if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_fs got=%b exp=1", frame_start); end
        end
        if (v == 20 && h == 10) begin
          checks++;
          if ({vo_r, vo_g, vo_b} !== 24'h0A1400) begin
            errors++; $display("[TB] FAIL frame_cnt_reset got=%h exp=0A1400", {vo_r, vo_g, vo_b});
          end
        end
      end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_first_line();
    test_bars();
    test_frame();
    test_solid();
    test_grid();
    test_gradient();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
